avalon_sram_bridge: RTL and testbench

Avalon-MM slave that sits directly downstream of the mips_cpu_bus master and replaces the behavioural RAM model with a synthesizable path to a synchronous single-port SRAM. It translates CPU byte addresses in the boot window (BASE_ADDR upward) into SRAM word addresses and inserts a programmable number of wait states. It also flags out-of-range, misaligned or malformed requests and keeps read and write transaction counters for bench and debug use.

---
 rtl/avalon_sram_bridge.sv | 147 ++++++++++++++
 tb/tb_avalon_sram_bridge.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_sram_bridge.sv
// Avalon-MM slave bridging the CPU boot window onto a synchronous SRAM.
// Adds programmable wait states, sticky error capture and transaction counters.
module avalon_sram_bridge #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          ADDR_W      = 14,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              waitrequest,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [3:0]        sram_be,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic              bus_error,
    output logic [31:0]       err_address,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;

    // 33-bit window bounds so the top of the window cannot wrap
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'd4 << ADDR_W);
    localparam logic [ADDR_W-1:0] BASE_W = BASE_ADDR[ADDR_W+1:2];
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        rd_q, wr_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] err_addr_q;
    logic [31:0] rd_cnt_q, wr_cnt_q;

    logic        req;
    logic        req_ok;
    logic        in_win;
    logic        acc;
    logic        fin;

    assign req    = read | write;
    assign in_win = ({1'b0, address} >= WIN_LO) && ({1'b0, address} < WIN_HI);
    assign req_ok = (read ^ write) && (address[1:0] == 2'b00) && in_win;
    assign acc    = (state_q == S_ACCESS);
    assign fin    = (state_q == S_DONE) || (state_q == S_ERR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (!req_ok) begin
                        state_d = S_ERR;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_ACCESS;
                else cnt_d = cnt_q - 4'd1;
            end
            S_ACCESS: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign waitrequest = !fin;
    assign sram_en     = acc;
    assign sram_we     = acc & wr_q;
    assign sram_addr   = acc ? (addr_q[ADDR_W+1:2] - BASE_W) : '0;
    assign sram_be     = (acc & wr_q) ? be_q : 4'd0;
    assign sram_wdata  = (acc & wr_q) ? wdata_q : 32'd0;

    always_comb begin
        readdata = rdata_q;
        if (state_q == S_DONE && rd_q) readdata = sram_rdata;
        if (state_q == S_ERR && rd_q)  readdata = ERR_DATA;
    end

    assign bus_error   = err_q;
    assign err_address = err_addr_q;
    assign rd_count    = rd_cnt_q;
    assign wr_count    = wr_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
            err_addr_q <= 32'd0;
            rd_cnt_q   <= 32'd0;
            wr_cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && req) begin
                addr_q  <= address;
                wdata_q <= writedata;
                be_q    <= byteenable;
                rd_q    <= read;
                wr_q    <= write;
            end
            if (fin && rd_q) rdata_q <= readdata;
            if (state_q == S_ERR) begin
                err_q <= 1'b1;
                if (!err_q) err_addr_q <= addr_q;
            end
            // read&write both high is tallied as a read
            if (fin) begin
                if (rd_q) rd_cnt_q <= rd_cnt_q + 32'd1;
                else wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_avalon_sram_bridge.sv
// Bench for avalon_sram_bridge: one instance with one wait state, one with none.
// Each drives its own SRAM model and is checked against a transaction-level model.
module tb_avalon_sram_bridge;

    localparam logic [31:0] BASE = 32'hBFC00000;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;
    localparam int          NW   = 16384;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic [31:0] address [2];
    logic        read [2];
    logic        write [2];
    logic [31:0] writedata [2];
    logic [3:0]  byteenable [2];
    logic [31:0] readdata [2];
    logic        waitrequest [2];
    logic        sram_en [2];
    logic        sram_we [2];
    logic [13:0] sram_addr [2];
    logic [3:0]  sram_be [2];
    logic [31:0] sram_wdata [2];
    logic [31:0] sram_rdata [2];
    logic        bus_error [2];
    logic [31:0] err_address [2];
    logic [31:0] rd_count [2];
    logic [31:0] wr_count [2];

    logic [31:0] mem [2][NW];
    logic        pl_en [2];
    logic [13:0] pl_addr [2];
    logic [31:0] pl_data [2];
    int          en_cnt [2] = '{0, 0};
    logic [13:0] last_addr [2];
    int          cyc = 0;

    logic [31:0] refm [2][NW];
    int          mrd [2];
    int          mwr [2];
    bit          merr [2];
    logic [31:0] meaddr [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    avalon_sram_bridge #(.WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(rst_n[0]), .address(address[0]), .read(read[0]),
        .write(write[0]), .writedata(writedata[0]), .byteenable(byteenable[0]),
        .readdata(readdata[0]), .waitrequest(waitrequest[0]),
        .sram_en(sram_en[0]), .sram_we(sram_we[0]), .sram_addr(sram_addr[0]),
        .sram_be(sram_be[0]), .sram_wdata(sram_wdata[0]), .sram_rdata(sram_rdata[0]),
        .bus_error(bus_error[0]), .err_address(err_address[0]),
        .rd_count(rd_count[0]), .wr_count(wr_count[0])
    );

    avalon_sram_bridge #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(rst_n[1]), .address(address[1]), .read(read[1]),
        .write(write[1]), .writedata(writedata[1]), .byteenable(byteenable[1]),
        .readdata(readdata[1]), .waitrequest(waitrequest[1]),
        .sram_en(sram_en[1]), .sram_we(sram_we[1]), .sram_addr(sram_addr[1]),
        .sram_be(sram_be[1]), .sram_wdata(sram_wdata[1]), .sram_rdata(sram_rdata[1]),
        .bus_error(bus_error[1]), .err_address(err_address[1]),
        .rd_count(rd_count[1]), .wr_count(wr_count[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_sram
        always @(posedge clk) begin
            if (pl_en[g]) mem[g][pl_addr[g]] <= pl_data[g];
            if (sram_en[g]) begin
                en_cnt[g] <= en_cnt[g] + 1;
                last_addr[g] <= sram_addr[g];
                sram_rdata[g] <= mem[g][sram_addr[g]];
                if (sram_we[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (sram_be[g][b])
                            mem[g][sram_addr[g]][b*8 +: 8] <= sram_wdata[g][b*8 +: 8];
                end
            end
        end
    end

    function automatic int ws(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic preload(input int k, input int w, input logic [31:0] v);
        pl_en[k] = 1'b1;
        pl_addr[k] = 14'(w);
        pl_data[k] = v;
        @(posedge clk); #1;
        pl_en[k] = 1'b0;
        refm[k][w] = v;
    endtask

    // Transaction-level reference: decode, latency class and memory effect
    task automatic model(input int k, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         output bit err, output logic [31:0] exp_rd, output int w);
        longint la;
        la = longint'(a);
        err = (rd && wr) || (a % 4 != 0) || (la < longint'(BASE))
              || (la >= longint'(BASE) + 4 * NW);
        exp_rd = 32'd0;
        w = 0;
        if (err) begin
            exp_rd = ERRD;
            if (!merr[k]) meaddr[k] = a;
            merr[k] = 1'b1;
        end else begin
            w = int'((la - longint'(BASE)) / 4);
            if (rd) exp_rd = refm[k][w];
            else
                for (int b = 0; b < 4; b++)
                    if (be[b]) refm[k][w][b*8 +: 8] = wd[b*8 +: 8];
        end
        if (rd) mrd[k]++;
        else mwr[k]++;
    endtask

    task automatic do_txn(input int k, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be, input bit scr,
                          output logic [31:0] rdata, output int lat);
        read[k] = rd;
        write[k] = wr;
        address[k] = a;
        writedata[k] = wd;
        byteenable[k] = be;
        lat = 0;
        rdata = 32'd0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (scr) begin
                address[k] = $urandom;
                writedata[k] = $urandom;
                byteenable[k] = 4'($urandom);
            end
            if (!waitrequest[k]) begin
                lat = i;
                rdata = readdata[k];
                break;
            end
        end
        read[k] = 1'b0;
        write[k] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_status(input int k, input string tag);
        chk({tag, " rd_count"}, rd_count[k], 32'(mrd[k]));
        chk({tag, " wr_count"}, wr_count[k], 32'(mwr[k]));
        chk({tag, " bus_error"}, {31'd0, bus_error[k]}, {31'd0, merr[k]});
        chk({tag, " err_address"}, err_address[k], meaddr[k]);
    endtask

    task automatic run(input int k, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be, input bit scr,
                       input string tag, output logic [31:0] got, output int lat);
        bit          err;
        logic [31:0] exp_rd;
        int          w, e0;
        model(k, rd, wr, a, wd, be, err, exp_rd, w);
        e0 = en_cnt[k];
        do_txn(k, rd, wr, a, wd, be, scr, got, lat);
        chk({tag, " latency"}, 32'(lat), err ? 32'd1 : 32'(ws(k) + 2));
        if (rd) chk({tag, " readdata"}, got, exp_rd);
        chk({tag, " sram_en pulses"}, 32'(en_cnt[k] - e0), err ? 32'd0 : 32'd1);
        if (!err) chk({tag, " sram_addr"}, {18'd0, last_addr[k]}, 32'(w));
        check_status(k, tag);
    endtask

    typedef struct {
        bit          pre;
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        bit          err;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [12];

    initial begin
        logic [31:0] got;
        int          lat;
        int          t [3];
        bit          found;

        vt[0]  = '{0, 0, 1, 32'hBFC00400, 32'h12345678, 4'hF, 0, 32'h0};
        vt[1]  = '{0, 1, 0, 32'hBFC00400, 32'h0, 4'h0, 0, 32'h12345678};
        vt[2]  = '{1, 0, 1, 32'hBFC00400, 32'h11223344, 4'b0101, 0, 32'h0};
        vt[3]  = '{0, 1, 0, 32'hBFC00400, 32'h0, 4'h0, 0, 32'hAA22CC44};
        vt[4]  = '{0, 1, 0, 32'hBFC10000, 32'h0, 4'h0, 1, 32'hDEADBEEF};
        vt[5]  = '{0, 1, 0, 32'h00000000, 32'h0, 4'h0, 1, 32'hDEADBEEF};
        vt[6]  = '{0, 1, 0, 32'hBFC00002, 32'h0, 4'h0, 1, 32'hDEADBEEF};
        vt[7]  = '{0, 1, 1, 32'hBFC00400, 32'h0, 4'hF, 1, 32'hDEADBEEF};
        vt[8]  = '{0, 0, 1, 32'hBFC0FFFC, 32'hCAFEF00D, 4'hF, 0, 32'h0};
        vt[9]  = '{0, 1, 0, 32'hBFC0FFFC, 32'h0, 4'h0, 0, 32'hCAFEF00D};
        vt[10] = '{0, 0, 1, 32'hBFC00000, 32'hFFFFFFFF, 4'h0, 0, 32'h0};
        vt[11] = '{0, 1, 0, 32'hBFC00000, 32'h0, 4'h0, 0, 32'h0};

        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0;
            read[k] = 1'b0;
            write[k] = 1'b0;
            address[k] = 32'd0;
            writedata[k] = 32'd0;
            byteenable[k] = 4'd0;
            pl_en[k] = 1'b0;
            pl_addr[k] = 14'd0;
            pl_data[k] = 32'd0;
            mrd[k] = 0;
            mwr[k] = 0;
            merr[k] = 1'b0;
            meaddr[k] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset waitrequest", {31'd0, waitrequest[k]}, 32'd1);
            chk("reset readdata", readdata[k], 32'd0);
            chk("reset sram_en", {31'd0, sram_en[k]}, 32'd0);
            chk("reset sram_addr", {18'd0, sram_addr[k]}, 32'd0);
            check_status(k, "reset");
            rst_n[k] = 1'b1;
        end
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < 64; w++) preload(k, w, 32'd0);
        preload(0, 16'h3FFF, 32'd0);

        for (int i = 0; i < 12; i++) begin
            if (vt[i].pre) preload(0, 16'h100, 32'hAABBCCDD);
            run(0, vt[i].rd, vt[i].wr, vt[i].a, vt[i].wd, vt[i].be, 1'b0,
                $sformatf("vec%0d", i), got, lat);
            chk($sformatf("vec%0d table latency", i), 32'(lat), vt[i].err ? 32'd1 : 32'd3);
            if (vt[i].rd) chk($sformatf("vec%0d table readdata", i), got, vt[i].exp);
        end
        chk("first err_address", err_address[0], 32'hBFC10000);

        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 40; n++) begin
                int          kind;
                bit          rd, wr;
                logic [31:0] a;
                kind = $urandom_range(0, 9);
                rd = 1'($urandom);
                wr = !rd;
                a = BASE + 32'(4 * $urandom_range(0, 15));
                if (kind == 0) a = a | 32'($urandom_range(1, 3));
                if (kind == 1) a = ($urandom % 2) ? 32'hBFBFFFFC
                                                  : 32'hBFC10000 + 32'(4 * $urandom_range(0, 1023));
                if (kind == 2) begin
                    rd = 1'b1;
                    wr = 1'b1;
                end
                run(k, rd, wr, a, $urandom, 4'($urandom), 1'b1,
                    $sformatf("rnd k%0d n%0d", k, n), got, lat);
            end
        end

        for (int i = 0; i < 3; i++)
            run(1, 1'b0, 1'b1, BASE + 32'h80 + 32'(4 * i), 32'hB0B00000 + 32'(i), 4'hF,
                1'b0, "b2b setup", got, lat);
        read[1] = 1'b1;
        address[1] = BASE + 32'h80;
        for (int i = 0; i < 3; i++) begin
            found = 1'b0;
            t[i] = 0;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                if (!waitrequest[1]) begin
                    found = 1'b1;
                    t[i] = cyc;
                    chk($sformatf("b2b read%0d", i), readdata[1], refm[1][32 + i]);
                    address[1] = BASE + 32'h80 + 32'(4 * (i + 1));
                    break;
                end
            end
            if (!found) chk($sformatf("b2b timeout%0d", i), 32'd1, 32'd0);
        end
        read[1] = 1'b0;
        mrd[1] += 3;
        @(posedge clk); #1;
        chk("b2b spacing 0-1", 32'(t[1] - t[0]), 32'd3);
        chk("b2b spacing 1-2", 32'(t[2] - t[1]), 32'd3);
        check_status(1, "b2b");

        write[0] = 1'b1;
        address[0] = BASE + 32'h200;
        writedata[0] = 32'h55555555;
        byteenable[0] = 4'hF;
        lat = en_cnt[0];
        @(posedge clk); #1;
        rst_n[0] = 1'b0;
        #1;
        chk("abort waitrequest", {31'd0, waitrequest[0]}, 32'd1);
        chk("abort sram_en", {31'd0, sram_en[0]}, 32'd0);
        @(posedge clk); #1;
        chk("abort sram_en held", {31'd0, sram_en[0]}, 32'd0);
        write[0] = 1'b0;
        rst_n[0] = 1'b1;
        mrd[0] = 0;
        mwr[0] = 0;
        merr[0] = 1'b0;
        meaddr[0] = 32'd0;
        @(posedge clk); #1;
        chk("abort no strobe", 32'(en_cnt[0] - lat), 32'd0);
        chk("abort sram intact", mem[0][128], refm[0][128]);
        check_status(0, "abort");
        run(0, 1'b0, 1'b1, BASE + 32'h200, 32'h0BADF00D, 4'hF, 1'b0, "post-abort wr", got, lat);
        run(0, 1'b1, 1'b0, BASE + 32'h200, 32'h0, 4'h0, 1'b0, "post-abort rd", got, lat);
        chk("post-abort data", got, 32'h0BADF00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
